// File: rtl/mul_pipe_lanes_pkg.sv
// Shared widths for the bicubic interpolation datapath.
// Pixel/weight widths, weight fraction bits and tap count.
package mul_pipe_lanes_pkg;
  localparam int PIX_W    = 10;
  localparam int WGT_W    = 18;
  localparam int WGT_FRAC = 16;
  localparam int TAPS     = 4;
endpackage

// File: rtl/mul_pipe_lane.sv
// One multiplier lane: S1 multiply, S2 round/shift, S3 format.
// Ports: clk, rst_n, ce, ld[2:0] (valid feeding S1..S3), a, b, p, sat.
module mul_pipe_lane
  import mul_pipe_lanes_pkg::*;
#(
  parameter int A_W      = PIX_W,
  parameter int B_W      = WGT_W,
  parameter int B_SIGNED = 1,
  parameter int SHIFT    = 0,
  parameter int CLAMP    = 0,
  parameter int OUT_W    = 28
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [2:0]       ld,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [OUT_W-1:0] p,
  output logic             sat
);
  localparam int P_W = A_W + B_W;
  localparam int R_W = P_W + 1;
  localparam int W   = ((R_W > OUT_W) ? R_W : OUT_W) + 1;
  localparam logic [R_W-1:0] RND =
    (R_W'(1) << SHIFT) >> 1;
  localparam logic signed [W-1:0] MAXV =
    {{(W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  logic [P_W-1:0] a_x, b_x, prod, prod_q;
  logic [R_W-1:0] sum, rnd, r_q;
  logic signed [W-1:0] rx;
  logic neg, over, sat_d;
  logic [OUT_W-1:0] p_d;

  // Modulo-2^P_W multiply is exact: the true product fits P_W bits.
  assign a_x  = P_W'(a);
  assign b_x  = {{A_W{(B_SIGNED != 0) & b[B_W-1]}}, b};
  assign prod = a_x * b_x;

  // One guard bit so the rounding add cannot wrap.
  assign sum = {(B_SIGNED != 0) & prod_q[P_W-1], prod_q} + RND;
  assign rnd = R_W'($signed(sum) >>> SHIFT);

  assign rx   = W'($signed(r_q));
  assign neg  = rx[W-1];
  assign over = !neg && (rx > MAXV);

  always_comb begin
    p_d   = rx[OUT_W-1:0];
    sat_d = 1'b0;
    if (CLAMP != 0) begin
      sat_d = neg || over;
      if (neg)
        p_d = '0;
      else if (over)
        p_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
      r_q    <= '0;
      p      <= '0;
      sat    <= 1'b0;
    end else if (ce) begin
      if (ld[0]) prod_q <= prod;
      if (ld[1]) r_q    <= rnd;
      if (ld[2]) begin
        p   <= p_d;
        sat <= sat_d;
      end
    end
  end
endmodule

// File: rtl/mul_pipe_lanes.sv
// Multi-lane pipelined pixel x weight multiplier with round/clamp.
// Ports: clk, rst_n, ce, in_valid/in_a/in_b/in_tag, out_valid/out_p/out_tag/out_sat.
module mul_pipe_lanes
  import mul_pipe_lanes_pkg::*;
#(
  parameter int LANES    = TAPS,
  parameter int A_W      = PIX_W,
  parameter int B_W      = WGT_W,
  parameter int B_SIGNED = 1,
  parameter int SHIFT    = 0,
  parameter int CLAMP    = 0,
  parameter int OUT_W    = 28,
  parameter int LATENCY  = 4,
  parameter int TAG_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ce,
  input  logic                   in_valid,
  input  logic [LANES*A_W-1:0]   in_a,
  input  logic [LANES*B_W-1:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  output logic [LANES*OUT_W-1:0] out_p,
  output logic [TAG_W-1:0]       out_tag,
  output logic [LANES-1:0]       out_sat
);
  localparam int D = LATENCY - 3;

  generate
    if (LATENCY < 3 || OUT_W < 1) begin : g_bad
      $error("mul_pipe_lanes: LATENCY>=3, OUT_W>=1");
    end
    if (SHIFT < 0 || SHIFT >= A_W + B_W) begin : g_bad_sh
      $error("mul_pipe_lanes: SHIFT out of range");
    end
  endgenerate

  // vin[k] is the valid that feeds stage k+1.
  logic [LATENCY-1:0] vld, vin;
  logic [LANES*OUT_W-1:0] p3;
  logic [LANES-1:0] s3;
  logic [TAG_W-1:0] tag_q [LATENCY];

  assign vin = {vld[LATENCY-2:0], in_valid};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vld <= '0;
    else if (ce)
      vld <= vin;
  end

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      mul_pipe_lane #(
        .A_W(A_W), .B_W(B_W), .B_SIGNED(B_SIGNED),
        .SHIFT(SHIFT), .CLAMP(CLAMP), .OUT_W(OUT_W)
      ) u_lane (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .ld(vin[2:0]),
        .a(in_a[i*A_W +: A_W]),
        .b(in_b[i*B_W +: B_W]),
        .p(p3[i*OUT_W +: OUT_W]),
        .sat(s3[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LATENCY; k++)
        tag_q[k] <= '0;
    end else if (ce) begin
      if (vin[0]) tag_q[0] <= in_tag;
      for (int k = 1; k < LATENCY; k++)
        if (vin[k]) tag_q[k] <= tag_q[k-1];
    end
  end

  generate
    if (D == 0) begin : g_nodly
      assign out_p   = p3;
      assign out_sat = s3;
    end else begin : g_dly
      logic [LANES*OUT_W-1:0] dp [D];
      logic [LANES-1:0] ds [D];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < D; j++) begin
            dp[j] <= '0;
            ds[j] <= '0;
          end
        end else if (ce) begin
          if (vin[3]) begin
            dp[0] <= p3;
            ds[0] <= s3;
          end
          for (int j = 1; j < D; j++)
            if (vin[3+j]) begin
              dp[j] <= dp[j-1];
              ds[j] <= ds[j-1];
            end
        end
      end
      assign out_p   = dp[D-1];
      assign out_sat = ds[D-1];
    end
  endgenerate

  assign out_valid = vld[LATENCY-1];
  assign out_tag   = tag_q[LATENCY-1];
endmodule

// File: tb/tb_mul_pipe_lanes.sv
// Bench for mul_pipe_lanes: three configurations, beat-level model.
// Directed vectors plus hand-computed literal expectations.
module tb_mul_pipe_lanes;
  localparam int NL  [3] = '{1, 2, 4};
  localparam int SG  [3] = '{0, 1, 1};
  localparam int SH  [3] = '{0, 16, 16};
  localparam int CL  [3] = '{0, 0, 1};
  localparam int OW  [3] = '{28, 12, 10};
  localparam int LAT [3] = '{4, 3, 6};

  logic clk = 0;
  logic rst_n = 0;
  logic ce = 1;
  logic in_valid = 0;
  logic [7:0] in_tag = 0;
  logic [39:0] in_a = 0;
  logic [71:0] in_b = 0;

  logic v0, v1, v2;
  logic [27:0] p0;
  logic [23:0] p1;
  logic [39:0] p2;
  logic [7:0] t0, t1, t2;
  logic [0:0] s0;
  logic [1:0] s1;
  logic [3:0] s2;

  always #5 clk = ~clk;

  mul_pipe_lanes #(
    .LANES(1), .A_W(10), .B_W(18), .B_SIGNED(0), .SHIFT(0),
    .CLAMP(0), .OUT_W(28), .LATENCY(4), .TAG_W(8)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .in_a(in_a[9:0]), .in_b(in_b[17:0]), .in_tag(in_tag),
    .out_valid(v0), .out_p(p0), .out_tag(t0), .out_sat(s0)
  );

  mul_pipe_lanes #(
    .LANES(2), .A_W(10), .B_W(18), .B_SIGNED(1), .SHIFT(16),
    .CLAMP(0), .OUT_W(12), .LATENCY(3), .TAG_W(8)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .in_a(in_a[19:0]), .in_b(in_b[35:0]), .in_tag(in_tag),
    .out_valid(v1), .out_p(p1), .out_tag(t1), .out_sat(s1)
  );

  mul_pipe_lanes #(
    .LANES(4), .A_W(10), .B_W(18), .B_SIGNED(1), .SHIFT(16),
    .CLAMP(1), .OUT_W(10), .LATENCY(6), .TAG_W(8)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(v2), .out_p(p2), .out_tag(t2), .out_sat(s2)
  );

  typedef struct {
    int k;
    logic [7:0] tag;
    logic [2:0][39:0] p;
    logic [2:0][3:0] s;
  } beat_t;

  beat_t beats[$];
  int rd [3] = '{0, 0, 0};
  int last [3] = '{-1, -1, -1};
  int cnt = 0;
  int tests = 0;
  int fails = 0;
  logic [7:0] seen[$];

  // Arithmetic meaning of one lane result, straight from the rules.
  function automatic longint fmt(int d, longint a,
                                 logic [17:0] b, output bit s);
    longint bv, r, mx;
    bv = (SG[d] != 0) ? longint'($signed(b)) : longint'(b);
    r = a * bv;
    if (SH[d] > 0)
      r = (r + (longint'(1) << (SH[d] - 1))) >>> SH[d];
    mx = (longint'(1) << OW[d]) - 1;
    s = 0;
    if (CL[d] != 0) begin
      if (r < 0) begin s = 1; r = 0; end
      else if (r > mx) begin s = 1; r = mx; end
    end
    return r & mx;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge rst_n) begin
    beats.delete();
    for (int d = 0; d < 3; d++) begin
      rd[d] = 0;
      last[d] = -1;
    end
    cnt = 0;
  end

  // Model: beat accepted on ce edge k shows up after edge k+LAT-1.
  always @(posedge clk) begin
    if (rst_n && ce) begin
      beat_t b;
      bit s;
      longint v;
      for (int d = 0; d < 3; d++)
        if (rd[d] < beats.size() &&
            beats[rd[d]].k + LAT[d] - 1 == cnt) begin
          last[d] = rd[d];
          rd[d]++;
        end
      if (v2) seen.push_back(t2);
      cnt++;
      if (in_valid) begin
        b.k = cnt;
        b.tag = in_tag;
        for (int d = 0; d < 3; d++) begin
          b.p[d] = '0;
          b.s[d] = '0;
          for (int i = 0; i < NL[d]; i++) begin
            v = fmt(d, longint'(in_a[i*10 +: 10]),
                    in_b[i*18 +: 18], s);
            for (int j = 0; j < OW[d]; j++)
              b.p[d][i*OW[d] + j] = v[j];
            b.s[d][i] = s;
          end
        end
        beats.push_back(b);
      end
    end
  end

  logic ev, av;
  logic [39:0] ep, ap;
  logic [7:0] et, at;
  logic [3:0] es, as;
  int idx;

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      ev = rd[d] < beats.size() &&
           beats[rd[d]].k + LAT[d] - 1 == cnt;
      idx = ev ? rd[d] : last[d];
      ep = '0; et = '0; es = '0;
      if (idx >= 0) begin
        ep = beats[idx].p[d];
        et = beats[idx].tag;
        es = beats[idx].s[d];
      end
      case (d)
        0: begin av = v0; ap = 40'(p0); at = t0; as = 4'(s0); end
        1: begin av = v1; ap = 40'(p1); at = t1; as = 4'(s1); end
        default: begin av = v2; ap = p2; at = t2; as = s2; end
      endcase
      tests++;
      if ({av, ap, at, as} !== {ev, ep, et, es}) begin
        fails++;
        $display("FAIL dut%0d t=%0t: got v=%b p=%h tag=%h sat=%b, expected v=%b p=%h tag=%h sat=%b",
                 d, $time, av, ap, at, as, ev, ep, et, es);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(logic [39:0] a, logic [71:0] b,
                      logic [7:0] t);
    in_valid = 1;
    in_a = a;
    in_b = b;
    in_tag = t;
    tick();
    in_valid = 0;
  endtask

  task automatic idle(int n);
    in_valid = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    bit s;
    longint r;
    logic [7:0] want[$];

    // Pin the model on hand-computed values.
    r = fmt(0, 1023, 18'h3FFFF, s);
    chk("model_legacy", 64'(r), 64'h0FFBFC01);
    r = fmt(1, 100, 18'h38000, s);
    chk("model_neg_half", 64'(r), 64'hFCE);
    r = fmt(2, 1000, 18'd98304, s);
    chk("model_clamp_hi", {63'(r), s}, {63'd1023, 1'b1});

    tick();
    chk("reset_out", {v0, v1, v2, p2, t2, s2}, '0);
    tick();
    rst_n = 1;
    idle(2);

    // Legacy 10x18 unsigned product, latency 4.
    beat({4{10'd1023}}, {4{18'h3FFFF}}, 8'hA1);
    idle(2);
    chk("legacy_early", 64'(v0), 64'd0);
    idle(1);
    chk("legacy_valid", 64'(v0), 64'd1);
    chk("legacy_p", 64'(p0), 64'h0FFBFC01);
    chk("legacy_tag", 64'(t0), 64'hA1);
    idle(4);

    // Signed round: lane0 b=-0.5, lane1 b=+0.5.
    beat({4{10'd100}},
         {18'd0, 18'd0, 18'd32768, 18'h38000}, 8'hB2);
    idle(1);
    chk("round_early", 64'(v1), 64'd0);
    idle(1);
    chk("round_valid", 64'(v1), 64'd1);
    chk("round_p", 64'(p1), 64'({12'd50, 12'hFCE}));
    idle(6);

    // Clamp: lanes {98304, -16384, 65536, 32769}.
    beat({4{10'd1000}},
         {18'd32769, 18'd65536, 18'h3C000, 18'd98304}, 8'hC3);
    idle(4);
    chk("clamp_early", 64'(v2), 64'd0);
    idle(1);
    chk("clamp_valid", 64'(v2), 64'd1);
    chk("clamp_p", 64'(p2),
        64'({10'd500, 10'd1000, 10'd0, 10'd1023}));
    chk("clamp_sat", 64'(s2), 64'b0011);
    idle(8);

    // Stall: six tags, ce low three cycles after the third.
    seen.delete();
    for (int t = 1; t <= 6; t++) begin
      if (t == 4) begin
        ce = 0;
        in_valid = 1;
        in_tag = 8'hEE;
        in_a = '1;
        tick(); tick(); tick();
        ce = 1;
      end
      beat({4{10'(t * 97)}},
           {18'(t * 20000), 18'(-t * 7000),
            18'(t * 65536), 18'(-t * 1234)}, 8'(t));
    end
    idle(10);
    want = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
    chk("stall_count", 64'(seen.size()), 64'd6);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      chk("stall_order", 64'(seen[i]), 64'(want[i]));

    // Mid-pipe stall with a beat in flight, ce toggling.
    beat({10'd3, 10'd200, 10'd511, 10'd1},
         {18'h20000, 18'h1FFFF, 18'd70000, 18'd5}, 8'h40);
    ce = 0; tick(); ce = 1; tick();
    ce = 0; tick(); tick(); ce = 1;
    idle(8);

    // Bubbles 1,0,0,1.
    beat({4{10'd321}}, {4{18'd40000}}, 8'h51);
    idle(2);
    beat({4{10'd77}}, {4{18'h30000}}, 8'h52);
    idle(8);

    // Reset with three beats in flight.
    beat({4{10'd900}}, {4{18'd1000}}, 8'h61);
    beat({4{10'd901}}, {4{18'd2000}}, 8'h62);
    beat({4{10'd902}}, {4{18'd3000}}, 8'h63);
    rst_n = 0;
    #1;
    chk("rst_valid", 64'({v0, v1, v2}), 64'd0);
    chk("rst_p", 64'(p2), 64'd0);
    chk("rst_tag_sat", 64'({t0, t1, t2, s0, s1, s2}), 64'd0);
    tick();
    rst_n = 1;
    idle(10);
    beat({4{10'd5}}, {4{18'd131072}}, 8'h70);
    idle(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
